alu_rr_sched: RTL and testbench

- Round-robin scheduler that shares one combinational 4-bit ALU (3-bit op: 000→0, 001 add, 010 sub, 011 and, 100 or, 101 ~A, 110 ~B, 111→0) between NREQ requesters.
- Accepts one operation per requester via valid/ready and drives registered operands to the ALU.
- Captures the ALU result and returns it, tagged with the requester ID, through a valid/ready response port.
- Sits between the requesting engines and the shared ALU instance.

---
 rtl/alu_rr_sched.sv | 145 ++++++++++++++
 tb/tb_alu_rr_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_rr_sched : round-robin scheduler sharing one combinational ALU among
//                NREQ requesters, returning tagged results via valid/ready.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module alu_rr_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_op,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [2:0]         alu_op,
  input  logic [DW-1:0]      alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]  alu_a_q, alu_a_d;
  logic [DW-1:0]  alu_b_q, alu_b_d;
  logic [2:0]     alu_op_q, alu_op_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic           rsp_zero_q, rsp_zero_d;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;

  // Scan from rr_ptr upward with wrap at NREQ; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        // ready is held low while reset is asserted
        if (found && rst_n) begin
          req_ready[winner] = 1'b1;
          alu_a_d  = req_a[int'(winner)*DW +: DW];
          alu_b_d  = req_b[int'(winner)*DW +: DW];
          alu_op_d = req_op[int'(winner)*3 +: 3];
          rsp_id_d = winner;
          rr_ptr_d = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_result;
        rsp_zero_d  = (alu_result == '0);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// tb_alu_rr_sched: scoreboard bench for alu_rr_sched with directed and
// randomized requesters and a behavioural ALU on the shared-ALU port.
module tb_alu_rr_sched;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int IDW  = 2;
  localparam int M    = 1 << DW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a = '0;
  logic [NREQ*DW-1:0] req_b = '0;
  logic [NREQ*3-1:0]  req_op = '0;
  logic [DW-1:0]      alu_a, alu_b, alu_result;
  logic [2:0]         alu_op;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_zero;
  logic               busy;

  int total = 0;
  int bad   = 0;
  logic [NREQ-1:0] granted = '0;

  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int ptr = 0, cyc = 0, win = 0;
  int last_a = 0, last_b = 0, last_op = 0;
  int exp_rdy = 0, exp_rv = 0, cand = 0;

  always #5 clk = ~clk;

  alu_rr_sched #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  function automatic int alu_f(input int op, input int a, input int b);
    case (op)
      1: return (a + b) % M;
      2: return (a - b + M) % M;
      3: return a & b;
      4: return a | b;
      5: return (~a) & (M - 1);
      6: return (~b) & (M - 1);
      default: return 0;
    endcase
  endfunction

  always_comb alu_result = DW'(alu_f(int'(alu_op), int'(alu_a), int'(alu_b)));

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_alu_op", int'(alu_op), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_data", int'(rsp_data), 0);
      chk("rst_rsp_zero", int'(rsp_zero), 0);
      q.delete();
      ptr = 0; last_a = 0; last_b = 0; last_op = 0;
    end else begin
      win = -1;
      exp_rdy = 0;
      if (q.size() == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          cand = (ptr + k) % NREQ;
          if (win < 0 && req_valid[cand]) win = cand;
        end
      end
      if (win >= 0) exp_rdy = 1 << win;
      chk("req_ready", int'(req_ready), exp_rdy);
      chk("busy", int'(busy), int'(q.size() != 0));
      chk("alu_a", int'(alu_a), last_a);
      chk("alu_b", int'(alu_b), last_b);
      chk("alu_op", int'(alu_op), last_op);
      exp_rv = int'(q.size() != 0 && cyc >= q[0].cyc + 2);
      chk("rsp_valid", int'(rsp_valid), exp_rv);
      if (exp_rv != 0 && rsp_valid) begin
        chk("rsp_id", int'(rsp_id), q[0].id);
        chk("rsp_data", int'(rsp_data), q[0].data);
        chk("rsp_zero", int'(rsp_zero), int'(q[0].data == 0));
        if (rsp_ready) void'(q.pop_front());
      end
      if (win >= 0) begin
        last_a  = int'(req_a[win*DW +: DW]);
        last_b  = int'(req_b[win*DW +: DW]);
        last_op = int'(req_op[win*3 +: 3]);
        e.id   = win;
        e.data = alu_f(last_op, last_a, last_b);
        e.cyc  = cyc;
        q.push_back(e);
        ptr = (win + 1) % NREQ;
        granted[win] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input int op);
    req_valid[i]        = 1'b1;
    req_a[i*DW +: DW]   = DW'(a);
    req_b[i*DW +: DW]   = DW'(b);
    req_op[i*3 +: 3]    = 3'(op);
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    while (!granted[i] && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("grant_req%0d", i), int'(granted[i]), 1);
  endtask

  task automatic issue(input int i, input int a, input int b, input int op);
    set_req(i, a, b, op);
    wait_grant(i);
    req_valid[i] = 1'b0;
    granted[i]   = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    granted   = '0;
    rsp_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic drive_cycles(input int n, input logic [NREQ-1:0] mask,
                              input int vpct, input int rpct);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i]) begin
          granted[i]   = 1'b0;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && mask[i] && $urandom_range(99) < vpct)
          set_req(i, int'($urandom), int'($urandom), int'($urandom));
      end
      rsp_ready = ($urandom_range(99) < rpct);
      tick();
    end
  endtask

  task automatic pulse_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    granted   = '0;
    #1;
    chk("async_rst_rsp_valid", int'(rsp_valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_req_ready", int'(req_ready), 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    issue(0, 9, 8, 1);
    for (int op = 0; op < 8; op++) issue(2, 5, 3, op);
    idle(4);

    drive_cycles(25, 4'hF, 100, 100);
    idle(4);
    drive_cycles(20, 4'b1010, 100, 100);
    idle(4);

    drive_cycles(3, 4'hF, 100, 100);
    drive_cycles(12, 4'hF, 100, 0);
    drive_cycles(10, 4'hF, 100, 100);
    idle(4);

    rsp_ready = 1'b1;
    issue(2, 7, 7, 2);
    pulse_reset();
    idle(3);

    rsp_ready = 1'b0;
    issue(1, 4, 6, 1);
    tick();
    pulse_reset();
    rsp_ready = 1'b1;
    set_req(0, 3, 1, 4);
    set_req(2, 6, 2, 3);
    wait_grant(0);
    chk("post_reset_req2_not_first", int'(granted[2]), 0);
    idle(6);

    drive_cycles(400, 4'hF, 40, 60);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
